// File: rtl/fifo_rd_pkg.sv
// Shared helpers for the FIFO read-side packer: lane-count width and pack ratio legality.
package fifo_rd_pkg;

    // Width needed to hold a lane count in the range 0..ratio.
    function automatic int unsigned lanes_width(input int unsigned ratio);
        return $clog2(ratio + 1);
    endfunction

    function automatic bit ratio_legal(input int unsigned ratio);
        return (ratio >= 2) && (ratio <= 16);
    endfunction

endpackage

// File: rtl/fifo_rd_outreg.sv
// Output holding register for packed words; loads only when free, drops valid on accept.
module fifo_rd_outreg #(
    parameter int unsigned data_w = 32,
    parameter int unsigned lane_w = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [data_w-1:0] load_data,
    input  logic [lane_w-1:0] load_lanes,
    input  logic              load_last,
    input  logic              ready,
    output logic              free,
    output logic [data_w-1:0] data,
    output logic [lane_w-1:0] lanes,
    output logic              last,
    output logic              valid
);

    logic [data_w-1:0] data_q;
    logic [lane_w-1:0] lanes_q;
    logic              last_q;
    logic              valid_q;

    assign free  = ~valid_q | ready;
    assign data  = data_q;
    assign lanes = lanes_q;
    assign last  = last_q;
    assign valid = valid_q;

    // The producer only raises load while free, so a held word is never overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            lanes_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            lanes_q <= load_lanes;
            last_q  <= load_last;
            valid_q <= 1'b1;
        end else if (ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: pops entries, packs pack_ratio of them per word, supports flush.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int unsigned data_size  = 8,
    parameter int unsigned pack_ratio = 4
) (
    input  logic                                  rclk,
    input  logic                                  rrst,
    input  logic                                  rempty,
    output logic                                  rinc,
    input  logic [data_size-1:0]                  r_data,
    input  logic                                  i_flush,
    output logic [data_size*pack_ratio-1:0]       o_data,
    output logic [lanes_width(pack_ratio)-1:0]    o_lanes,
    output logic                                  o_last,
    output logic                                  o_valid,
    input  logic                                  o_ready
);

    localparam int unsigned LaneW = lanes_width(pack_ratio);
    localparam int unsigned WordW = data_size * pack_ratio;
    localparam logic [LaneW-1:0] FullCnt = LaneW'(pack_ratio);

    if (!ratio_legal(pack_ratio)) begin : g_ratio_check
        $error("fifo_rd_packer: pack_ratio must be in 2..16");
    end

    logic [WordW-1:0] acc_q, acc_d, acc_fill;
    logic [LaneW-1:0] cnt_q, cnt_d, cnt_fill;
    logic             pend_q;
    logic             flush_q, flush_d;
    logic             out_free;
    logic             load;
    logic [LaneW-1:0] load_lanes;
    logic             load_last;

    // Count the in-flight pop so the accumulator never overflows.
    assign rinc = ~rrst & ~rempty & ~flush_q & ((cnt_q + LaneW'(pend_q)) < FullCnt);

    always_comb begin
        acc_fill = acc_q;
        cnt_fill = cnt_q;
        if (pend_q) begin
            for (int i = 0; i < int'(pack_ratio); i++) begin
                if (cnt_q == LaneW'(i)) begin
                    acc_fill[i*data_size +: data_size] = r_data;
                end
            end
            cnt_fill = cnt_q + LaneW'(1);
        end

        acc_d      = acc_fill;
        cnt_d      = cnt_fill;
        flush_d    = flush_q | i_flush;
        load       = 1'b0;
        load_lanes = cnt_fill;
        load_last  = 1'b0;

        if (cnt_fill == FullCnt) begin
            // A full word leaves nothing pending, so it also satisfies any flush.
            if (out_free) begin
                load      = 1'b1;
                load_last = flush_q | i_flush;
                flush_d   = 1'b0;
            end
        end else if (flush_q && !pend_q && out_free) begin
            load      = (cnt_q != '0);
            load_last = 1'b1;
            flush_d   = 1'b0;
        end

        // Clearing on load keeps unused lanes of the next partial word at zero.
        if (load) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pend_q  <= rinc;
            flush_q <= flush_d;
        end
    end

    fifo_rd_outreg #(
        .data_w(WordW),
        .lane_w(LaneW)
    ) u_outreg (
        .clk       (rclk),
        .rst       (rrst),
        .load      (load),
        .load_data (acc_fill),
        .load_lanes(load_lanes),
        .load_last (load_last),
        .ready     (o_ready),
        .free      (out_free),
        .data      (o_data),
        .lanes     (o_lanes),
        .last      (o_last),
        .valid     (o_valid)
    );

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the async FIFO, running in the read clock domain. It pops `data_size`-bit entries through the FIFO read port (`rinc`/`rempty`/`r_data`) and packs `pack_ratio` consecutive entries into one wide word. It presents each word on a valid/ready stream and supports an explicit flush that emits a partial word.

## Interface
Parameters:
- `data_size`, 8: FIFO entry width; must match the FIFO instance.
- `pack_ratio`, 4: entries per output word; legal range 2..16.

Ports:
- `rclk` input 1: read-domain clock; the only clock.
- `rrst` input 1: synchronous, active-high reset.
- `rempty` input 1: FIFO empty flag.
- `rinc` output 1: FIFO pop request; a pop occurs at an edge where `rinc & ~rempty`.
- `r_data` input `data_size`: FIFO read data, registered one edge after the pop.
- `i_flush` input 1: one-cycle pulse requesting emission of any partial word.
- `o_data` output `data_size*pack_ratio`: packed word; the first-popped entry is in bits [`data_size`-1:0].
- `o_lanes` output `clog2(pack_ratio+1)`: number of valid lanes in `o_data`.
- `o_last` output 1: word was produced by a flush.
- `o_valid` output 1: output word valid.
- `o_ready` input 1: downstream accepts the word when `o_valid & o_ready`.

## Operation
Internal state:
- `acc`: lane accumulator.
- `cnt`: committed lanes, 0..`pack_ratio`.
- `pend`: a pop was issued at the previous edge.
- `flush_req`: sticky flush request.
- Output register: `o_data`, `o_lanes`, `o_last`, `o_valid`.

Control:
- `rinc = ~rrst & ~rempty & ~flush_req & (cnt + pend < pack_ratio)`. Combinational, never asserted while `rempty`.
- Capture: on an edge with `pend=1`, write `r_data` into lane `cnt`, then increment `cnt`.
- The output register is "free" when `~o_valid | o_ready`.
- Completion:
  - A capture that fills lane `pack_ratio-1` while the output register is free loads the output register directly: `o_lanes=pack_ratio`, `o_last=flush_req`, `cnt=0`.
  - If the output register is not free, `cnt` holds at `pack_ratio` and the word transfers on the first free edge.
- Flush:
  - `i_flush` sets `flush_req`, which blocks new pops.
  - Once `pend=0` and the output register is free: if `cnt>0`, emit the partial word (`o_lanes=cnt`, `o_last=1`, `cnt=0`); if `cnt==0`, emit nothing. In both cases clear `flush_req`.
  - `i_flush` arriving while `flush_req` is already set has no additional effect.
- Unused lanes of a partial word are zero.
- `o_valid` falls on an accept edge unless a new word loads on the same edge.

## Timing
- Reset values: `o_valid=0`, `o_data=0`, `o_lanes=0`, `o_last=0`, `cnt=0`, `pend=0`, `flush_req=0`, `rinc=0`.
- Reset mid-operation: an in-flight pop (`pend=1`) is discarded. That entry is lost because the FIFO pointer has already advanced. Any held output word is dropped.
- Latency: first pop at edge E with the FIFO continuously non-empty and `o_ready=1` gives `o_valid` high after edge E+`pack_ratio`.
- Throughput: one pop-free bubble per word (`pack_ratio` entries every `pack_ratio+1` cycles).
- Backpressure: `o_data`, `o_lanes` and `o_last` are stable while `o_valid & ~o_ready`. The accumulator keeps filling up to `pack_ratio` lanes, then stalls `rinc`.
- `rempty` asserting mid-word: pops pause and `cnt` holds indefinitely; no timeout.
- Simultaneous `i_flush` and a completing capture: the full word is emitted with `o_last=1` and the flush is satisfied.

## Structure
- Shared package/header `fifo_rd_pkg`: lane-count width function `clog2(pack_ratio+1)` and the `pack_ratio` legality check.
- Sub-module `fifo_rd_outreg`: the output holding register with valid/ready load/accept logic. Pop control, accumulator and flush sequencing stay in the top.

## Test plan
- Reset, then write 0x11,0x22,0x33,0x44 into the FIFO with `o_ready=1` -> one word `o_data=0x44332211`, `o_lanes=4`, `o_last=0`, `o_valid` high after edge E+4.
- Stream 12 entries 0x00..0x0B -> words 0x03020100, 0x07060504, 0x0B0A0908, with exactly one `rinc` bubble per word.
- Hold `o_ready=0` while 8 entries are available -> first word held stable, accumulator fills to 4, `rinc` low. Release `o_ready` -> second word appears on the next edge.
- Write 0xAA,0xBB, then pulse `i_flush` -> `o_data=0x0000BBAA`, `o_lanes=2`, `o_last=1`. A flush with `cnt=0` -> no output word.
- Assert `rrst` one cycle after a pop -> all outputs reset, that entry is not captured, and the next word starts from the following entry.
- Pulse `i_flush` on the edge that captures lane 3 -> full word emitted with `o_last=1` and no extra empty word.
